// File: rtl/ctrl_seq_pkg.sv
// Shared state encodings and opcodes for the control sequencer and the control-output decoder.
// The HALT code is only reachable when the design is built with CTRL_SEQ_HALT_EN.
package ctrl_seq_pkg;

  localparam int STATE_W_P  = 5;
  localparam int OPC_W_P    = 4;
  localparam int RETIRE_W_P = 16;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_IRLD   = 5'd1,
    S_LOAD   = 5'd2,
    S_MOVE   = 5'd3,
    S_LDPC   = 5'd4,
    S_BRANCH = 5'd5,
    S_SUB0   = 5'd6,
    S_SUB1   = 5'd7,
    S_SUB2   = 5'd8,
    S_ADD0   = 5'd9,
    S_ADD1   = 5'd10,
    S_ADD2   = 5'd11,
    S_XOR0   = 5'd12,
    S_XOR1   = 5'd13,
    S_XOR2   = 5'd14,
    S_RAMRD  = 5'd15,
    S_HALT   = 5'd16,
    S_TRAP   = 5'd17
  } state_e;

  localparam logic [3:0] OPC_LOAD   = 4'h0;
  localparam logic [3:0] OPC_MOVE   = 4'h1;
  localparam logic [3:0] OPC_LDPC   = 4'h2;
  localparam logic [3:0] OPC_BRANCH = 4'h3;
  localparam logic [3:0] OPC_SUB    = 4'h4;
  localparam logic [3:0] OPC_ADD    = 4'h5;
  localparam logic [3:0] OPC_XOR    = 4'h6;
  localparam logic [3:0] OPC_HALT   = 4'h7;

  // Last execute cycle of every legal instruction; the sequencer returns to fetch afterwards.
  function automatic logic is_final_state(input state_e s);
    return (s == S_LOAD) || (s == S_MOVE) || (s == S_LDPC) || (s == S_BRANCH) ||
           (s == S_SUB2) || (s == S_ADD2) || (s == S_XOR2);
  endfunction

  function automatic logic is_parked_state(input state_e s);
    return (s == S_FETCH) || (s == S_TRAP) || (s == S_HALT);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Instruction sequencer: fetch (0 -> 15 -> 1), opcode decode, execute steps, trap and retire count.
// Define CTRL_SEQ_HALT_EN to make opcode 4'h7 enter the HALT state instead of trapping.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int STATE_W  = STATE_W_P,
  parameter int OPC_W    = OPC_W_P,
  parameter int RETIRE_W = RETIRE_W_P
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_wait,
  input  logic [15:0]         instr,
  output logic [STATE_W-1:0]  state,
  output logic                busy,
  output logic                instr_done,
  output logic                illegal,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_e              state_q, state_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic [OPC_W-1:0]    opcode;
  logic                unused_instr_bits;

  assign opcode            = instr[15 -: OPC_W];
  assign unused_instr_bits = ^instr[15-OPC_W:0];

  // Next-state logic; any code outside the legal set falls into TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (run) state_d = S_RAMRD;
      S_RAMRD: if (!mem_wait) state_d = S_IRLD;
      S_IRLD: begin
        case (opcode)
          OPC_LOAD:   state_d = S_LOAD;
          OPC_MOVE:   state_d = S_MOVE;
          OPC_LDPC:   state_d = S_LDPC;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_SUB:    state_d = S_SUB0;
          OPC_ADD:    state_d = S_ADD0;
          OPC_XOR:    state_d = S_XOR0;
`ifdef CTRL_SEQ_HALT_EN
          OPC_HALT:   state_d = S_HALT;
`endif
          default:    state_d = S_TRAP;
        endcase
      end
      S_LOAD, S_MOVE, S_LDPC, S_BRANCH,
      S_SUB2, S_ADD2, S_XOR2: state_d = S_FETCH;
      S_SUB0:  state_d = S_SUB1;
      S_SUB1:  state_d = S_SUB2;
      S_ADD0:  state_d = S_ADD1;
      S_ADD1:  state_d = S_ADD2;
      S_XOR0:  state_d = S_XOR1;
      S_XOR1:  state_d = S_XOR2;
`ifdef CTRL_SEQ_HALT_EN
      S_HALT:  state_d = S_HALT;
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    retire_d  = retire_q + RETIRE_W'(is_final_state(state_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
    end
  end

  assign state      = STATE_W'(state_q);
  assign busy       = !is_parked_state(state_q);
  assign instr_done = is_final_state(state_q);
  assign illegal    = illegal_q;
  assign retire_cnt = retire_q;

`ifdef CTRL_SEQ_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
